mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access controller for the pipelined LC-3b. It takes the EX/MEM instruction, the effective address and the forwarded store data, and runs the memory handshake for LDW/LDB/LDI/STW/STB/STI/TRAP. It stalls the upstream pipeline until the access completes, then delivers load/trap data to the MEM/WB register. It sits directly downstream of the store-data forwarding logic, which supplies `store_data_in`.

## Interface
Parameters: none.

- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `valid_in` input 1: EX/MEM register holds a valid instruction.
- `ir_in` input 16: EX/MEM instruction word.
- `addr_in` input 16: effective address from EX. For TRAP, this is ZEXT(trapvect8)<<1.
- `store_data_in` input 16: forwarded SR value for STW/STB/STI.
- `mem_rdata` input 16: memory read data, valid when `mem_resp`=1.
- `mem_resp` input 1: memory access complete.
- `mem_address` output 16: access address, registered.
- `mem_read` output 1: read request, registered.
- `mem_write` output 1: write request, registered.
- `mem_byte_enable` output 2: [1]=high byte, [0]=low byte, registered.
- `mem_wdata` output 16: write data, registered.
- `stall_out` output 1: freeze PC, IF/ID, ID/EX and EX/MEM registers. Combinational.
- `wb_valid` output 1: one-cycle pulse; `wb_data` holds a load/trap result.
- `wb_data` output 16: result for the MEM/WB register, registered.

## Operation
- Memory ops are decoded from `ir_in[15:12]`: LDB 0010, STB 0011, LDW 0110, STW 0111, LDI 1010, STI 1011, TRAP 1111. Every other opcode is ignored. For those opcodes `stall_out`=0, `wb_valid`=0 and the state machine stays in IDLE.
- States: IDLE, ACCESS, INDIRECT, DONE.
- **IDLE**
  - When `valid_in` is high and the opcode is a memory op, latch `ir_in`, `addr_in` and `store_data_in` into internal registers, then go to ACCESS.
  - Issue the first request on the same edge as the latch.
  - Store data is latched here; changes on `store_data_in` during the stall are ignored.
- **First request**
  - LDW, TRAP, LDI, STI: `mem_read`=1, address {addr[15:1],0}, byte enable 11.
  - LDB: `mem_read`=1, address {addr[15:1],0}.
  - STW: `mem_write`=1, address {addr[15:1],0}, byte enable 11, `mem_wdata`=SR.
  - STB: `mem_write`=1, address {addr[15:1],0}, byte enable = addr[0] ? 10 : 01, `mem_wdata`={SR[7:0],SR[7:0]}.
- **ACCESS**
  - Hold the request unchanged until `mem_resp`.
  - On `mem_resp` with LDI or STI: drop the request and go to INDIRECT.
  - The second request is issued on the same edge, at address {mem_rdata[15:1],0}.
    - LDI: read, byte enable 11.
    - STI: write, `mem_wdata`=SR, byte enable 11.
  - On `mem_resp` with any other op: drop the request, capture the result into `wb_data`, go to DONE.
- **INDIRECT**: hold the request until `mem_resp`, then drop it, capture the result and go to DONE.
- **Result capture**
  - LDW, LDI, TRAP: `wb_data`=mem_rdata.
  - LDB: `wb_data`=SEXT(addr[0] ? rdata[15:8] : rdata[7:0]).
  - Stores: `wb_data` is unchanged.
- **DONE**
  - Lasts exactly one cycle and always returns to IDLE.
  - `wb_valid`=1 for loads and TRAP, 0 for stores.
  - `stall_out`=0, so the pipeline advances.
  - A new memory op presented in the following cycle is accepted from IDLE.
- **stall_out** is 1 in any of these cases:
  - IDLE with a valid memory op present;
  - ACCESS;
  - INDIRECT.

  It is 0 otherwise.
- `mem_resp` is ignored in IDLE and DONE.
- `mem_read` and `mem_write` are never both 1.

## Timing
- **Reset values**: state IDLE; `mem_read`, `mem_write`, `wb_valid` = 0; `mem_address`, `mem_wdata`, `wb_data` = 0x0000; `mem_byte_enable` = 00. `stall_out` is then 0 unless a memory op is present.
- **Reset mid-access**: the request drops on the same edge. A `mem_resp` arriving afterwards is ignored. No `wb_valid` pulse is produced.
- **Single-access latency, zero-wait memory**:
  - C0: IDLE, stall=1.
  - C1: ACCESS, request high, `mem_resp`=1.
  - C2: DONE, `wb_valid`=1, stall=0.
  - Total: 3 cycles with stall high for C0–C1. Each memory wait cycle adds one.
- **Indirect latency, zero-wait memory**: 4 cycles, with stall high for C0–C2.
- Requests are held stable, with no glitches in address, data or enables, from issue until the cycle that samples `mem_resp`.

## Test plan
- **LDW**: addr 0x3005, memory returns 0xBEEF after 2 wait cycles. Expect address 0x3004, `mem_read` high for 3 cycles, then `wb_valid`=1 with 0xBEEF, stall high for 4 cycles total.
- **LDB sign extension**: addr 0x1001, rdata 0x8034. Expect `wb_data`=0xFF80. With addr 0x1000 and the same rdata, expect 0x0034.
- **STB**: addr 0x2001, SR 0x12AB. Expect byte enable 10, wdata 0xABAB, `mem_write` only, `wb_valid`=0 in DONE. Also change `store_data_in` mid-stall and confirm wdata stays 0xABAB.
- **LDI**: addr 0x0040, pointer read returns 0x5003, second read returns 0x7777.
  - Expect a second read at 0x5002.
  - Expect `wb_data`=0x7777.
  - Zero-wait memory gives 4-cycle latency.
- **STI**: the pointer read returns 0x6000, then expect a write to 0x6000 with the latched SR.
- **Reset during ACCESS of LDW**: the request drops the next cycle. A late `mem_resp` is ignored, there is no `wb_valid`, and the block is back in IDLE.
- **Back-to-back**: STW followed by LDW. The second op is accepted in the cycle after DONE with no lost or duplicated request. A non-memory op gives `stall_out`=0 with no request.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Memory bus between the LC-3b memory-stage access controller and the data memory.
// The controller is the master: it drives address, enables and write data, and
// the memory answers with read data and a completion strobe.
interface mem_access_unit_if;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_address,
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  modport slave (
    input  mem_address,
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage access controller for the pipelined LC-3b.
// Accepts LDW/LDB/LDI/STW/STB/STI/TRAP from EX/MEM, runs one or two memory
// transactions (two for the indirect forms), stalls the front of the pipeline
// until the access finishes and hands load/trap data to MEM/WB.
module mem_access_unit (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [15:0]        ir_in,
  input  logic [15:0]        addr_in,
  input  logic [15:0]        store_data_in,
  mem_access_unit_if.master  mem,
  output logic               stall_out,
  output logic               wb_valid,
  output logic [15:0]        wb_data
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACCESS   = 2'd1;
  localparam logic [1:0] ST_INDIRECT = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [3:0] OP_LDB  = 4'b0010;
  localparam logic [3:0] OP_STB  = 4'b0011;
  localparam logic [3:0] OP_LDW  = 4'b0110;
  localparam logic [3:0] OP_STW  = 4'b0111;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  logic [1:0]  state_reg, state_next;
  logic [3:0]  op_reg, op_next;
  logic        addr_lsb_reg, addr_lsb_next;
  logic [15:0] sr_reg, sr_next;
  logic [15:0] mem_address_reg, mem_address_next;
  logic        mem_read_reg, mem_read_next;
  logic        mem_write_reg, mem_write_next;
  logic [1:0]  mem_byte_enable_reg, mem_byte_enable_next;
  logic [15:0] mem_wdata_reg, mem_wdata_next;
  logic        wb_valid_reg, wb_valid_next;
  logic [15:0] wb_data_reg, wb_data_next;

  logic [3:0]  opcode;
  logic        accept;
  logic        unused_ir_bits;

  assign opcode = ir_in[15:12];
  // Only the opcode field matters here; the operand fields were consumed upstream.
  assign unused_ir_bits = ^ir_in[11:0];

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_STB) || (op == OP_LDW) || (op == OP_STW) ||
           (op == OP_LDI) || (op == OP_STI) || (op == OP_TRAP);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LDB) || (op == OP_LDW) || (op == OP_LDI) || (op == OP_TRAP);
  endfunction

  // LDB picks the addressed byte and sign-extends it; everything else is a full word.
  function automatic logic [15:0] load_result(input logic [3:0] op, input logic lsb,
                                              input logic [15:0] rdata);
    logic [7:0] byte_val;
    byte_val = lsb ? rdata[15:8] : rdata[7:0];
    if (op == OP_LDB) return {{8{byte_val[7]}}, byte_val};
    return rdata;
  endfunction

  assign accept = (state_reg == ST_IDLE) && valid_in && is_mem_op(opcode);

  // Hold the front of the pipeline while an op waits to start or is in flight.
  assign stall_out = accept || (state_reg == ST_ACCESS) || (state_reg == ST_INDIRECT);

  // Next-state and request/result computation for the access sequencer.
  always_comb begin
    state_next           = state_reg;
    op_next              = op_reg;
    addr_lsb_next        = addr_lsb_reg;
    sr_next              = sr_reg;
    mem_address_next     = mem_address_reg;
    mem_read_next        = mem_read_reg;
    mem_write_next       = mem_write_reg;
    mem_byte_enable_next = mem_byte_enable_reg;
    mem_wdata_next       = mem_wdata_reg;
    wb_valid_next        = 1'b0;
    wb_data_next         = wb_data_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          // Latch the op so later changes on the forwarded inputs cannot disturb it.
          op_next          = opcode;
          addr_lsb_next    = addr_in[0];
          sr_next          = store_data_in;
          mem_address_next = {addr_in[15:1], 1'b0};
          state_next       = ST_ACCESS;
          case (opcode)
            OP_STW: begin
              mem_read_next        = 1'b0;
              mem_write_next       = 1'b1;
              mem_byte_enable_next = 2'b11;
              mem_wdata_next       = store_data_in;
            end
            OP_STB: begin
              mem_read_next        = 1'b0;
              mem_write_next       = 1'b1;
              mem_byte_enable_next = addr_in[0] ? 2'b10 : 2'b01;
              mem_wdata_next       = {store_data_in[7:0], store_data_in[7:0]};
            end
            default: begin
              // Loads, TRAP vector fetch and the pointer fetch of LDI/STI.
              mem_read_next        = 1'b1;
              mem_write_next       = 1'b0;
              mem_byte_enable_next = 2'b11;
            end
          endcase
        end
      end

      ST_ACCESS: begin
        if (mem.mem_resp) begin
          if ((op_reg == OP_LDI) || (op_reg == OP_STI)) begin
            // The returned word is the pointer; launch the real access right away.
            mem_address_next     = {mem.mem_rdata[15:1], 1'b0};
            mem_byte_enable_next = 2'b11;
            mem_read_next        = (op_reg == OP_LDI);
            mem_write_next       = (op_reg == OP_STI);
            if (op_reg == OP_STI) mem_wdata_next = sr_reg;
            state_next = ST_INDIRECT;
          end else begin
            mem_read_next  = 1'b0;
            mem_write_next = 1'b0;
            if (is_load(op_reg)) begin
              wb_data_next  = load_result(op_reg, addr_lsb_reg, mem.mem_rdata);
              wb_valid_next = 1'b1;
            end
            state_next = ST_DONE;
          end
        end
      end

      ST_INDIRECT: begin
        if (mem.mem_resp) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          if (is_load(op_reg)) begin
            wb_data_next  = load_result(op_reg, addr_lsb_reg, mem.mem_rdata);
            wb_valid_next = 1'b1;
          end
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // One release cycle so the pipeline advances before a new op is taken.
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops any outstanding request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= ST_IDLE;
      op_reg              <= 4'h0;
      addr_lsb_reg        <= 1'b0;
      sr_reg              <= 16'h0000;
      mem_address_reg     <= 16'h0000;
      mem_read_reg        <= 1'b0;
      mem_write_reg       <= 1'b0;
      mem_byte_enable_reg <= 2'b00;
      mem_wdata_reg       <= 16'h0000;
      wb_valid_reg        <= 1'b0;
      wb_data_reg         <= 16'h0000;
    end else begin
      state_reg           <= state_next;
      op_reg              <= op_next;
      addr_lsb_reg        <= addr_lsb_next;
      sr_reg              <= sr_next;
      mem_address_reg     <= mem_address_next;
      mem_read_reg        <= mem_read_next;
      mem_write_reg       <= mem_write_next;
      mem_byte_enable_reg <= mem_byte_enable_next;
      mem_wdata_reg       <= mem_wdata_next;
      wb_valid_reg        <= wb_valid_next;
      wb_data_reg         <= wb_data_next;
    end
  end

  assign mem.mem_address     = mem_address_reg;
  assign mem.mem_read        = mem_read_reg;
  assign mem.mem_write       = mem_write_reg;
  assign mem.mem_byte_enable = mem_byte_enable_reg;
  assign mem.mem_wdata       = mem_wdata_reg;
  assign wb_valid            = wb_valid_reg;
  assign wb_data             = wb_data_reg;

endmodule
